// File: rtl/perf_counter_pkg.sv
// Shared constants for the performance counter bank: counter overflow modes
// and the supported channel limit.
package perf_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;
  localparam int MAX_N_CH  = 16;

endpackage

// File: rtl/perf_counter_channel.sv
// One event-counter channel: clear priority chain, carry-based overflow
// detection, sticky overflow flag and a registered compare-match pulse.
module perf_counter_channel
  import perf_counter_pkg::*;
#(
  parameter int CNT_WIDTH = 64,
  parameter int SATURATE  = MODE_WRAP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_all,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 ovf_clr,
  input  logic [CNT_WIDTH-1:0] cmp_val,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf,
  output logic                 cmp_hit
);

  logic [CNT_WIDTH:0]   sum;
  logic                 carry;
  logic                 clear;
  logic                 changed;
  logic [CNT_WIDTH-1:0] count_next;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    sum        = {1'b0, count} + (CNT_WIDTH+1)'(1);
    carry      = sum[CNT_WIDTH];
    clear      = clr_all | clr;
    changed    = 1'b0;
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (en) begin
      if (!(carry && SATURATE == MODE_SAT)) begin
        count_next = sum[CNT_WIDTH-1:0];
        changed    = 1'b1;
      end
    end
  end

  // A hit requires a value change, so clears and saturated holds never pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      ovf     <= 1'b0;
      cmp_hit <= 1'b0;
    end else begin
      count   <= count_next;
      cmp_hit <= changed && (count_next == cmp_val);
      if (clr_all)
        ovf <= 1'b0;
      else if (en && !clear && carry)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of independent event counters with atomic snapshot into shadow
// registers and a registered read mux.
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_WIDTH = 64,
  parameter int SATURATE  = MODE_WRAP,
  parameter int SEL_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_all,
  input  logic [N_CH-1:0]      clr,
  input  logic [N_CH-1:0]      en,
  input  logic [N_CH-1:0]      ovf_clr,
  input  logic [CNT_WIDTH-1:0] cmp_val,
  input  logic                 snap,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 snap_valid,
  output logic [N_CH-1:0]      ovf,
  output logic [N_CH-1:0]      cmp_hit
);

  logic [CNT_WIDTH-1:0] live   [N_CH];
  logic [CNT_WIDTH-1:0] shadow [N_CH];
  logic [CNT_WIDTH-1:0] rd_next;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    perf_counter_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clr_all (clr_all),
      .clr     (clr[g]),
      .en      (en[g]),
      .ovf_clr (ovf_clr[g]),
      .cmp_val (cmp_val),
      .count   (live[g]),
      .ovf     (ovf[g]),
      .cmp_hit (cmp_hit[g])
    );
  end

  // Out-of-range selects fall through to the zero default.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_next = shadow[i];
    end
  end

  // Shadows capture the pre-edge live counts, so a snap coinciding with a
  // clear still records the value before the clear.
  // NOTE: the shadow array is small and architecturally visible after reset,
  // so it is reset explicitly rather than left to a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
      snap_valid <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_data <= rd_next;
      if (snap) begin
        for (int i = 0; i < N_CH; i++) shadow[i] <= live[i];
        snap_valid <= 1'b1;
      end else if (clr_all) begin
        for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
        snap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: one wrapping and one saturating
// 8-bit instance, live counts observed through snapshot reads.
module tb_perf_counter_bank;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int SW   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            a_clr_all, b_clr_all;
  logic [N_CH-1:0] a_clr, a_en, a_ovf_clr, b_clr, b_en, b_ovf_clr;
  logic [W-1:0]    a_cmp_val, b_cmp_val, a_rd_data, b_rd_data;
  logic            a_snap, b_snap, a_snap_valid, b_snap_valid;
  logic [SW-1:0]   a_rd_sel, b_rd_sel;
  logic [N_CH-1:0] a_ovf, a_cmp_hit, b_ovf, b_cmp_hit;

  int tests = 0;
  int fails = 0;

  perf_counter_bank #(.N_CH(N_CH), .CNT_WIDTH(W), .SATURATE(0), .SEL_W(SW)) u_wrap (
    .clk(clk), .rst(rst), .clr_all(a_clr_all), .clr(a_clr), .en(a_en),
    .ovf_clr(a_ovf_clr), .cmp_val(a_cmp_val), .snap(a_snap), .rd_sel(a_rd_sel),
    .rd_data(a_rd_data), .snap_valid(a_snap_valid), .ovf(a_ovf), .cmp_hit(a_cmp_hit)
  );

  perf_counter_bank #(.N_CH(N_CH), .CNT_WIDTH(W), .SATURATE(1), .SEL_W(SW)) u_sat (
    .clk(clk), .rst(rst), .clr_all(b_clr_all), .clr(b_clr), .en(b_en),
    .ovf_clr(b_ovf_clr), .cmp_val(b_cmp_val), .snap(b_snap), .rd_sel(b_rd_sel),
    .rd_data(b_rd_data), .snap_valid(b_snap_valid), .ovf(b_ovf), .cmp_hit(b_cmp_hit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Snapshot then read channel ch of the wrapping instance.
  task automatic read_a(input int ch, input string tag, input logic [W-1:0] exp);
    a_snap = 1'b1; a_rd_sel = SW'(ch);
    tick();
    a_snap = 1'b0;
    tick();
    check(tag, a_rd_data, exp);
  endtask

  task automatic read_b(input int ch, input string tag, input logic [W-1:0] exp);
    b_snap = 1'b1; b_rd_sel = SW'(ch);
    tick();
    b_snap = 1'b0;
    tick();
    check(tag, b_rd_data, exp);
  endtask

  initial begin
    int hits;
    rst = 1'b1;
    a_clr_all = 0; a_clr = '0; a_en = '0; a_ovf_clr = '0; a_cmp_val = 8'h55;
    a_snap = 0; a_rd_sel = '0;
    b_clr_all = 0; b_clr = '0; b_en = '0; b_ovf_clr = '0; b_cmp_val = 8'h55;
    b_snap = 0; b_rd_sel = '0;

    // Reset state
    tick(); tick();
    check("rst_a_rd_data", a_rd_data, 0);
    check("rst_a_snap_valid", a_snap_valid, 0);
    check("rst_a_ovf", a_ovf, 0);
    check("rst_b_ovf", b_ovf, 0);
    check("rst_b_cmp_hit", b_cmp_hit, 0);
    rst = 1'b0;

    // Wrap mode: 0xFE -> 0xFF -> 0x00 with cmp_val = 0
    a_cmp_val = 8'h00;
    a_en[0] = 1'b1;
    for (int k = 0; k < 254; k++) tick();
    tick();
    check("wrap_ff_ovf", a_ovf[0], 0);
    check("wrap_ff_hit", a_cmp_hit[0], 0);
    tick();
    check("wrap_ovf_set", a_ovf[0], 1);
    check("wrap_hit_pulse", a_cmp_hit[0], 1);
    a_en[0] = 1'b0;
    tick();
    check("wrap_hit_one_cycle", a_cmp_hit[0], 0);
    read_a(0, "wrap_count_zero", 8'h00);
    check("snap_valid_set", a_snap_valid, 1);

    // Clear to zero never hits; clr alone keeps ovf; ovf_clr drops it
    a_en[0] = 1'b1; tick(); a_en[0] = 1'b0;
    a_clr[0] = 1'b1; tick(); a_clr[0] = 1'b0;
    check("clr_no_hit", a_cmp_hit[0], 0);
    check("clr_keeps_ovf", a_ovf[0], 1);
    a_ovf_clr[0] = 1'b1; tick(); a_ovf_clr[0] = 1'b0;
    check("ovf_clr", a_ovf[0], 0);

    // Saturate mode on ch1: 300 enables, exactly one hit at 0xFF
    b_cmp_val = 8'hFF;
    b_en[1] = 1'b1;
    hits = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (b_cmp_hit[1]) hits++;
    end
    b_en[1] = 1'b0;
    check("sat_hit_count", hits, 1);
    check("sat_ovf", b_ovf[1], 1);
    read_b(1, "sat_count_ff", 8'hFF);
    b_en[1] = 1'b1; b_ovf_clr[1] = 1'b1;
    tick();
    b_en[1] = 1'b0; b_ovf_clr[1] = 1'b0;
    check("sat_set_beats_clr", b_ovf[1], 1);
    check("sat_hold_no_hit", b_cmp_hit[1], 0);
    b_ovf_clr[1] = 1'b1; tick(); b_ovf_clr[1] = 1'b0;
    check("sat_ovf_clr", b_ovf[1], 0);

    // clr_all drops counts, flags and snap_valid
    a_clr_all = 1'b1; tick(); a_clr_all = 1'b0;
    check("clr_all_snap_valid", a_snap_valid, 0);
    check("clr_all_ovf", a_ovf, 0);

    // Atomic snapshot with counters running: 10,20,30,40
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N_CH; i++) a_en[i] = (k < 10 * (i + 1));
      tick();
    end
    a_en = 4'hF; a_snap = 1'b1; a_rd_sel = 4'd2;
    tick();
    a_snap = 1'b0;
    check("snap_rd_old_shadow", a_rd_data, 0);
    tick();
    a_en = '0;
    check("snap_rd_ch2", a_rd_data, 30);
    a_rd_sel = 4'd0; tick(); check("snap_rd_ch0", a_rd_data, 10);
    a_rd_sel = 4'd1; tick(); check("snap_rd_ch1", a_rd_data, 20);
    a_rd_sel = 4'd3; tick(); check("snap_rd_ch3", a_rd_data, 40);
    a_rd_sel = 4'd5; tick(); check("rd_sel_out_of_range", a_rd_data, 0);

    // Same-edge snap and read: old shadow first, new value next cycle
    a_snap = 1'b1; a_rd_sel = 4'd0;
    tick();
    a_snap = 1'b0;
    check("snap_read_same_edge_old", a_rd_data, 10);
    tick();
    check("snap_read_same_edge_new", a_rd_data, 12);

    // Priority: clr beats en; snap with clr keeps pre-clear value
    a_en[0] = 1'b1; a_clr[0] = 1'b1;
    tick();
    a_en[0] = 1'b0; a_clr[0] = 1'b0;
    check("clr_beats_en_ovf", a_ovf[0], 0);
    read_a(0, "clr_beats_en_count", 8'h00);
    a_en[0] = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    a_en[0] = 1'b0;
    a_snap = 1'b1; a_clr[0] = 1'b1; a_rd_sel = 4'd0;
    tick();
    a_snap = 1'b0; a_clr[0] = 1'b0;
    tick();
    check("snap_with_clr_pre_value", a_rd_data, 7);
    read_a(0, "snap_with_clr_after", 8'h00);

    // Reset mid-count at 123 with snap pending and a hit one step away
    a_cmp_val = 8'd124;
    a_en[0] = 1'b1;
    for (int k = 0; k < 123; k++) tick();
    rst = 1'b1; a_snap = 1'b1;
    tick();
    check("midrst_rd_data", a_rd_data, 0);
    check("midrst_snap_valid", a_snap_valid, 0);
    check("midrst_ovf", a_ovf, 0);
    check("midrst_cmp_hit", a_cmp_hit, 0);
    rst = 1'b0; a_snap = 1'b0; a_en[0] = 1'b0;
    tick();
    check("midrst_no_pulse", a_cmp_hit, 0);
    a_snap = 1'b1; a_rd_sel = 4'd0;
    tick();
    a_snap = 1'b0;
    check("midrst_shadow_zero", a_rd_data, 0);
    tick();
    check("midrst_count_zero", a_rd_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised bank of N_CH independent event counters for accelerator performance monitoring (busy cycles, ops issued, stalls).
- Successor to the single free-running counter: adds per-channel clear, selectable wrap/saturate mode, sticky overflow flags and a compare-match pulse.
- Atomic snapshot of all channels into shadow registers, read back through a registered index mux.
- Sits beside the AXI4-Lite wrapper: the wrapper drives snap/rd_sel/clears and returns rd_data.

Parameters:
N_CH, 4, number of counter channels (1..16)
CNT_WIDTH, 64, width of each counter (8..64)
SATURATE, 0, 0 = wrap to 0 past max; 1 = hold at max
SEL_W, 4, width of rd_sel; must satisfy 2**SEL_W >= N_CH

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
clr_all  in  1  clear all counters and all overflow flags
clr  in  N_CH  per-channel counter clear
en  in  N_CH  per-channel increment enable (count event)
ovf_clr  in  N_CH  per-channel overflow-flag clear
cmp_val  in  CNT_WIDTH  compare value shared by all channels
snap  in  1  capture all live counts into shadow registers
rd_sel  in  SEL_W  shadow register index
rd_data  out  CNT_WIDTH  registered shadow[rd_sel]
snap_valid  out  1  high once any snapshot has been taken since reset/clr_all
ovf  out  N_CH  sticky overflow flags
cmp_hit  out  N_CH  one-cycle pulse per channel on compare match

Behaviour:
- Reset: synchronous, active-high. All counts, shadows, rd_data, ovf, cmp_hit and snap_valid = 0 at the edge where rst = 1. Reset mid-count discards all state; no pulses issued.
- Per-channel counter priority: rst > clr_all > clr[i] > en[i]. The counter changes only on an edge where en[i] = 1 and no clear is active.
- Width: count is unsigned CNT_WIDTH; the increment is computed CNT_WIDTH+1 wide and the carry-out detects overflow.
- At max (all ones) with en[i]:
  - SATURATE=0: wrap to 0.
  - SATURATE=1: hold at max.
  - In both modes ovf[i] is set.
- ovf[i] is sticky. It is cleared by ovf_clr[i] or clr_all. If the overflow event and ovf_clr[i] fall on the same edge, set wins. clr[i] alone does not clear ovf[i].
- cmp_hit[i] is registered. It is high for exactly the cycle in which the live count first equals cmp_val through an increment that changed the value.
  - A clear to 0 never produces a hit, even with cmp_val = 0.
  - Wrap from max to 0 with cmp_val = 0 does produce a hit.
  - A saturated hold does not produce a hit.
- Snapshot: on an edge with snap = 1, shadow[i] takes the live count value present before that edge (pre-update) for all channels simultaneously. snap_valid <= 1.
  - snap and clr on the same edge: shadow holds the pre-clear value.
  - clr_all clears snap_valid and all shadows unless snap is also high; in that case shadows take the pre-clear values and snap_valid = 1.
- Read: rd_data <= (rd_sel < N_CH) ? shadow[rd_sel] : 0. Latency is one cycle.
  - snap and a read on the same edge: rd_data returns the old shadow; the new value appears one cycle later.
- No handshake. Inputs are sampled every edge; the caller guarantees that clr/ovf_clr/snap are single-cycle pulses when single-event semantics are wanted.

Decomposition:
- Package perf_counter_pkg: constants MODE_WRAP = 0 and MODE_SAT = 1, plus max N_CH.
- Sub-module perf_counter_channel: one channel containing count, ovf, cmp_hit, carry logic and the priority chain. It is instantiated N_CH times with a generate loop.
- The top level holds the shadow array, snap_valid and the rd_data mux.

Test Plan:
- CNT_WIDTH=8, SATURATE=0: preload to 0xFE via 254 enables, 2 more enables -> count 0x00, ovf[0]=1 from the wrap edge; cmp_val=0 -> cmp_hit[0] pulses for 1 cycle.
- SATURATE=1, CNT_WIDTH=8: 300 enables on ch1 -> count stays 0xFF, ovf[1]=1, cmp_val=0xFF -> exactly one cmp_hit[1] pulse; same-edge ovf_clr[1] with an overflowing enable -> ovf[1] stays 1.
- Atomic snapshot: channels at 10, 20, 30, 40 with en all high, pulse snap -> shadows 10, 20, 30, 40; rd_sel=2 -> rd_data=30 one cycle later while live counts keep running.
- Priority: en[0] and clr[0] on the same edge -> count 0, ovf unchanged; snap with clr[0] on the same edge at count 7 -> shadow[0]=7.
- rd_sel=5 with N_CH=4 -> rd_data=0. snap and rd_sel=0 on the same edge -> old shadow returned, new value on the next cycle.
- rst asserted mid-count at 123 with snap pending -> next cycle all counts, shadows, ovf, cmp_hit, snap_valid and rd_data are 0; no cmp_hit pulse.
